rib_timer: RTL and testbench

Memory-mapped 32-bit timer that answers the core's RIB data-port requests (address, write data, write enable, request) as a bus responder and returns read data in the same cycle. It raises a level interrupt that feeds one bit of the core's `int_i` bus. It sits on the RIB interconnect beside RAM/ROM slaves and is used by QED/SQED benches as a deterministic interrupt source.

---
 rtl/rib_timer.sv | 141 ++++++++++++++
 tb/tb_rib_timer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rib_timer.sv
// rtl/rib_timer.sv - RIB memory-mapped 32-bit timer with level interrupt; optional prescaler under RIB_TIMER_PRESCALER_EN
module rib_timer #(
   parameter logic [31:0] CMP_RST = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        int_sig_o
);

   localparam logic [1:0] OFS_CTRL    = 2'd0;
   localparam logic [1:0] OFS_COUNT   = 2'd1;
   localparam logic [1:0] OFS_COMPARE = 2'd2;
   localparam logic [1:0] OFS_PSC     = 2'd3;

   logic        ctrl_en;
   logic        ctrl_ie;
   logic        ctrl_pend;
   logic        ctrl_oneshot;
   logic [31:0] count;
   logic [31:0] compare;
   logic [31:0] psc_rd;

   logic        wr;
   logic        rd;
   logic        ctrl_wr;
   logic        count_wr;
   logic        compare_wr;
   logic        tick;
   logic        match;

   // The interconnect already selected this slave; only the word offset matters.
   logic        unused_addr;
   assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

   assign wr         = req_i & we_i;
   assign rd         = req_i & ~we_i;
   assign ctrl_wr    = wr && (addr_i[3:2] == OFS_CTRL);
   assign count_wr   = wr && (addr_i[3:2] == OFS_COUNT);
   assign compare_wr = wr && (addr_i[3:2] == OFS_COMPARE);

`ifdef RIB_TIMER_PRESCALER_EN
   logic [15:0] psc;
   logic [15:0] div;
   logic        psc_wr;

   assign psc_wr = wr && (addr_i[3:2] == OFS_PSC);
   assign tick   = (div == psc);
   assign psc_rd = {16'h0, psc};

   // Prescaler divider: counts 0..PSC while enabled, restarts on strobe, disable or PSC write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         psc <= 16'h0;
         div <= 16'h0;
      end else begin
         if (psc_wr) begin
            psc <= data_i[15:0];
         end
         if (psc_wr || !ctrl_en || tick) begin
            div <= 16'h0;
         end else begin
            div <= div + 16'h1;
         end
      end
   end
`else
   assign tick   = 1'b1;
   assign psc_rd = 32'h0;
`endif

   // Match uses the COMPARE value held before any same-cycle write.
   assign match = ctrl_en && tick && (compare != 32'h0) && (count == compare);

   // COMPARE register: plain software RW.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         compare <= CMP_RST;
      end else if (compare_wr) begin
         compare <= data_i;
      end
   end

   // COUNT: software write wins over the tick; match reloads to zero, otherwise wraps freely.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= 32'h0;
      end else if (count_wr) begin
         count <= data_i;
      end else if (ctrl_en && tick) begin
         count <= match ? 32'h0 : count + 32'h1;
      end
   end

   // CTRL EN/IE/ONESHOT: software write of EN overrides the one-shot auto-disable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_en      <= 1'b0;
         ctrl_ie      <= 1'b0;
         ctrl_oneshot <= 1'b0;
      end else if (ctrl_wr) begin
         ctrl_en      <= data_i[0];
         ctrl_ie      <= data_i[1];
         ctrl_oneshot <= data_i[3];
      end else if (match && ctrl_oneshot) begin
         ctrl_en      <= 1'b0;
      end
   end

   // PEND: a match sets it even when software clears it in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_pend <= 1'b0;
      end else if (match) begin
         ctrl_pend <= 1'b1;
      end else if (ctrl_wr && data_i[2]) begin
         ctrl_pend <= 1'b0;
      end
   end

   // Zero-latency read mux; idle bus returns zero.
   always_comb begin
      data_o = 32'h0;
      if (rd) begin
         case (addr_i[3:2])
            OFS_CTRL:    data_o = {28'h0, ctrl_oneshot, ctrl_pend, ctrl_ie, ctrl_en};
            OFS_COUNT:   data_o = count;
            OFS_COMPARE: data_o = compare;
            OFS_PSC:     data_o = psc_rd;
            default:     data_o = 32'h0;
         endcase
      end
   end

   assign int_sig_o = ctrl_pend & ctrl_ie;

endmodule

// File: tb/tb_rib_timer.sv
// tb/tb_rib_timer.sv - scoreboard bench for rib_timer against a behavioural register model
module tb_rib_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = 32'h0;
   logic [31:0] data_i = 32'h0;
   logic [31:0] data_o;
   logic        int_sig_o;
   logic        rst_drive = 1'b0;

   rib_timer #(.CMP_RST(32'h0)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .data_i    (data_i),
      .data_o    (data_o),
      .int_sig_o (int_sig_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic        ie;
      logic        pend;
      logic        os;
      logic [31:0] count;
      logic [31:0] cmp;
   } model_t;

   typedef struct packed {
      logic [31:0] data;
      logic        irq;
      logic        rd;
      logic [1:0]  reg_idx;
   } exp_t;

   model_t m;
   exp_t   sb_q[$];
   int     checks = 0;
   int     errors = 0;

   function automatic logic [31:0] model_read(input model_t s, input logic [1:0] r);
      case (r)
         2'd0:    return {28'h0, s.os, s.pend, s.ie, s.en};
         2'd1:    return s.count;
         2'd2:    return s.cmp;
         default: return 32'h0;
      endcase
   endfunction

   // State after one clock: the timer advances, then software writes override per register.
   function automatic model_t model_step(input model_t s, input logic req, input logic we,
                                         input logic [1:0] r, input logic [31:0] d);
      model_t n = s;
      bit hit = s.en && (s.cmp != 0) && (s.count == s.cmp);
      bit w = req && we;
      if (s.en) n.count = hit ? 32'h0 : s.count + 32'h1;
      if (hit) begin
         n.pend = 1'b1;
         if (s.os) n.en = 1'b0;
      end
      if (w && r == 2'd0) begin
         n.en = d[0];
         n.ie = d[1];
         n.os = d[3];
         if (d[2] && !hit) n.pend = 1'b0;
      end
      if (w && r == 2'd1) n.count = d;
      if (w && r == 2'd2) n.cmp = d;
      return n;
   endfunction

   task automatic cycle(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      @(posedge clk);
      #1;
      rst    = rst_drive;
      req_i  = req;
      we_i   = we;
      addr_i = addr;
      data_i = data;
      if (!rst) m = '0;
      e.rd      = req && !we;
      e.reg_idx = addr[3:2];
      e.data    = e.rd ? model_read(m, addr[3:2]) : 32'h0;
      e.irq     = m.pend && m.ie;
      sb_q.push_back(e);
      if (rst) m = model_step(m, req, we, addr[3:2], data);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      cycle(1'b1, 1'b1, {$urandom} & 32'hFFFF_FFF0 | (addr & 32'hC), data);
   endtask

   task automatic rd(input logic [31:0] addr);
      cycle(1'b1, 1'b0, {$urandom} & 32'hFFFF_FFF0 | (addr & 32'hC), $urandom);
   endtask

   // Monitor: compares every cycle's bus outputs against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (data_o !== e.data) begin
               errors++;
               $display("FAIL data rd=%0d reg=%0d got %h want %h at %0t", e.rd, e.reg_idx, data_o, e.data, $time);
            end
            checks++;
            if (int_sig_o !== e.irq) begin
               errors++;
               $display("FAIL int_sig_o got %b want %b at %0t", int_sig_o, e.irq, $time);
            end
         end
      end
   end

   initial begin
      m = '0;
      rst_drive = 1'b0;
      repeat (3) cycle(1'b0, 1'b0, 32'h0, 32'h0);
      rst_drive = 1'b1;
      cycle(1'b0, 1'b0, 32'h0, 32'h0);

      // reset mid-count
      wr(32'h8, 32'h0);
      wr(32'h4, 32'h55);
      wr(32'h0, 32'h3);
      repeat (3) rd(32'h4);
      rst_drive = 1'b0;
      rd(32'h0);
      rd(32'h4);
      rd(32'h8);
      rd(32'hC);
      rst_drive = 1'b1;
      rd(32'h4);

      // periodic COMPARE = 4
      wr(32'h8, 32'h4);
      wr(32'h4, 32'h0);
      wr(32'h0, 32'h3);
      repeat (12) rd(32'h4);

      // W1C on a match cycle keeps PEND; on a non-match cycle clears it
      for (int i = 0; i < 10; i++) begin
         if (m.en && m.cmp != 0 && m.count == m.cmp) break;
         rd(32'h4);
      end
      wr(32'h0, 32'h7);
      rd(32'h0);
      wr(32'h0, 32'h7);
      rd(32'h0);
      rd(32'h0);

      // oneshot
      wr(32'h0, 32'h4);
      wr(32'h4, 32'h0);
      wr(32'h8, 32'h2);
      wr(32'h0, 32'hB);
      repeat (6) rd(32'h4);
      rd(32'h0);

      // wrap with COMPARE = 0, then an idle read
      wr(32'h0, 32'h4);
      wr(32'h8, 32'h0);
      wr(32'h4, 32'hFFFF_FFFE);
      wr(32'h0, 32'h3);
      repeat (4) rd(32'h4);
      rd(32'h0);
      cycle(1'b0, 1'b0, 32'h4, 32'h0);

      // PSC is absent in the default build
      wr(32'hC, $urandom);
      rd(32'hC);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic [1:0]  r;
         logic [31:0] d;
         int          op;
         r  = 2'($urandom_range(0, 3));
         op = $urandom_range(0, 3);
         case (r)
            2'd0:    d = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
            2'd1:    d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 8));
            2'd2:    d = 32'($urandom_range(0, 7));
            default: d = $urandom;
         endcase
         if (op < 2) rd({28'h0, r, 2'b00});
         else if (op == 2) wr({28'h0, r, 2'b00}, d);
         else cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end

      cycle(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
